// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall sequencer for the 5-stage core.
// Drives PC / IF-ID / ID-EX / EX-MEM enables, flushes and holds from a
// registered state plus a 16-bit cycle counter. Outputs are a combinational
// decode of state and current inputs, so stalls take effect in the same cycle.
// Priority in any cycle: memory wait > branch flush > load-use.
// Optional: define HAZ_PERF_CNT_EN to add saturating 32-bit event counters
// (lu_stall_count, flush_count, mem_wait_count).
module hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_IF_ID,
  input  logic [4:0] rs2_IF_ID,
  input  logic [4:0] rd_ID_EX,
  input  logic       Mem_Read_ID_EX,
  input  logic       branch_taken_EX,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       id_ex_hold,
  output logic       ex_mem_hold,
  output logic       mem_err,
  output logic [1:0] hz_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] lu_stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] mem_wait_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  localparam logic [15:0] LU_LAST    = 16'(LU_STALL_CYCLES - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(MEM_TIMEOUT);
  localparam bit          LU_MULTI   = (LU_STALL_CYCLES > 1);
  localparam bit          FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic mem_stall;
  logic lu_hit;
  logic do_hold;
  logic do_flush;
  logic do_lu;
  logic do_err;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hit    = Mem_Read_ID_EX & (rd_ID_EX != '0) &
                     ((rd_ID_EX == rs1_IF_ID) | (rd_ID_EX == rs2_IF_ID));

  // State and cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and control-pattern decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_hold  = 1'b0;
    do_flush = 1'b0;
    do_lu    = 1'b0;
    do_err   = 1'b0;
    // While reset is held all controls stay at their RUN values regardless of inputs.
    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            do_hold = 1'b1;
            state_d = ST_MEM_WAIT;
            cnt_d   = 16'd1;
          end else if (branch_taken_EX) begin
            do_flush = 1'b1;
            if (FLUSH_MULTI) begin
              state_d = ST_FLUSH;
              cnt_d   = 16'd1;
            end
          end else if (lu_hit) begin
            do_lu = 1'b1;
            if (LU_MULTI) begin
              state_d = ST_LU_STALL;
              cnt_d   = 16'd1;
            end
          end
        end
        ST_LU_STALL: begin
          if (mem_stall) begin
            do_hold = 1'b1;
            state_d = ST_MEM_WAIT;
            cnt_d   = 16'd1;
          end else if (branch_taken_EX) begin
            do_flush = 1'b1;
            if (FLUSH_MULTI) begin
              state_d = ST_FLUSH;
              cnt_d   = 16'd1;
            end else begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end else begin
            // The bubble has already advanced, so the hazard is not re-detected here.
            do_lu = 1'b1;
            if (cnt_q == LU_LAST) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_stall) begin
            // Ready cycle shows plain RUN controls; a held branch is seen next cycle.
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            do_hold = 1'b1;
            if (cnt_q == TO_LAST) begin
              do_err  = 1'b1;
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (mem_stall) begin
            do_hold = 1'b1;
            state_d = ST_MEM_WAIT;
            cnt_d   = 16'd1;
          end else begin
            do_flush = 1'b1;
            if (cnt_q == FLUSH_LAST) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Map control patterns onto the pipeline register controls
  always_comb begin
    pc_write    = ~(do_hold | do_lu);
    if_id_write = ~(do_hold | do_lu);
    if_id_flush = do_flush;
    id_ex_flush = do_flush | do_lu;
    id_ex_hold  = do_hold;
    ex_mem_hold = do_hold;
    mem_err     = do_err;
    hz_state    = state_q;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_cnt_q, flush_cnt_q, mw_cnt_q;

  // Saturating per-pattern event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
      mw_cnt_q    <= '0;
    end else begin
      if (do_lu && (lu_cnt_q != '1))       lu_cnt_q    <= lu_cnt_q + 32'd1;
      if (do_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (do_hold && (mw_cnt_q != '1))     mw_cnt_q    <= mw_cnt_q + 32'd1;
    end
  end

  assign lu_stall_count = lu_cnt_q;
  assign flush_count    = flush_cnt_q;
  assign mem_wait_count = mw_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, each
// cycle checked against a behavioural model built from remaining-bubble counts.
module tb_hazard_ctrl;

  localparam int LU = 3;
  localparam int FL = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       mrd, br, mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic       id_ex_hold, ex_mem_hold, mem_err;
  logic [1:0] hz_state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_stall_count, flush_count, mem_wait_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit m_wait;
  int m_wait_n, m_lu_left, m_fl_left;
  int m_lu_cnt, m_fl_cnt, m_mw_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .LU_STALL_CYCLES(LU),
    .FLUSH_CYCLES   (FL),
    .MEM_TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_IF_ID      (rs1),
    .rs2_IF_ID      (rs2),
    .rd_ID_EX       (rd),
    .Mem_Read_ID_EX (mrd),
    .branch_taken_EX(br),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .id_ex_hold     (id_ex_hold),
    .ex_mem_hold    (ex_mem_hold),
    .mem_err        (mem_err),
    .hz_state       (hz_state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .lu_stall_count (lu_stall_count),
    .flush_count    (flush_count),
    .mem_wait_count (mem_wait_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_wait_n = 0; m_lu_left = 0; m_fl_left = 0;
    m_lu_cnt = 0; m_fl_cnt = 0; m_mw_cnt = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step(input string tag);
    bit e_hold, e_flush, e_lu, e_err, mw, hit;
    int e_st;
    logic [8:0] exp_v, obs_v;
    #1;
    e_hold = 0; e_flush = 0; e_lu = 0; e_err = 0; e_st = 0;
    mw  = mem_req && !mem_ready;
    hit = mrd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    if (!rst_n) begin
      model_reset();
    end else begin
      e_st = m_wait ? 2 : (m_lu_left > 0) ? 1 : (m_fl_left > 0) ? 3 : 0;
      if (m_wait) begin
        if (mw) begin
          e_hold = 1;
          if (m_wait_n == TO) begin e_err = 1; m_wait = 0; end
          else m_wait_n++;
        end else begin
          m_wait = 0;
        end
      end else if (mw) begin
        e_hold = 1; m_wait = 1; m_wait_n = 1; m_lu_left = 0; m_fl_left = 0;
      end else if (m_fl_left > 0) begin
        e_flush = 1; m_fl_left--;
      end else if (br) begin
        e_flush = 1; m_lu_left = 0; m_fl_left = FL - 1;
      end else if (m_lu_left > 0) begin
        e_lu = 1; m_lu_left--;
      end else if (hit) begin
        e_lu = 1; m_lu_left = LU - 1;
      end
    end
    exp_v = {~(e_hold | e_lu), ~(e_hold | e_lu), e_flush, e_flush | e_lu,
             e_hold, e_hold, e_err, 2'(e_st)};
    obs_v = {pc_write, if_id_write, if_id_flush, id_ex_flush,
             id_ex_hold, ex_mem_hold, mem_err, hz_state};
    chk(tag, 32'(obs_v), 32'(exp_v));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, "_lucnt"}, lu_stall_count, 32'(m_lu_cnt));
    chk({tag, "_flcnt"}, flush_count, 32'(m_fl_cnt));
    chk({tag, "_mwcnt"}, mem_wait_count, 32'(m_mw_cnt));
    if (rst_n) begin
      if (e_lu) m_lu_cnt++;
      if (e_flush) m_fl_cnt++;
      if (e_hold) m_mw_cnt++;
    end
`endif
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; mrd = 0; br = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    int stuck;
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    // hazards present during reset must not show on the outputs
    rd = 5'd5; rs1 = 5'd5; mrd = 1; br = 1; mem_req = 1;
    step("reset_hold");
    idle_inputs();
    step("reset_idle");
    rst_n = 1;
    step("run_idle");

    // load-use on rs1: LU bubbles then RUN
    rd = 5'd5; rs1 = 5'd5; mrd = 1;
    step("lu_detect");
    step("lu_stall1");
    step("lu_stall2");
    idle_inputs();
    step("lu_done");

    // x0 is never a hazard
    rd = 5'd0; rs2 = 5'd0; mrd = 1;
    step("x0_nohaz");
    idle_inputs();

    // branch beats load-use
    rd = 5'd7; rs2 = 5'd7; mrd = 1; br = 1;
    step("br_over_lu");
    br = 0;
    step("br_flush2");
    idle_inputs();
    step("br_done");

    // memory wait 4 cycles then ready
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) step("mw_wait");
    mem_ready = 1; br = 1;
    step("mw_ready");
    mem_req = 0; mem_ready = 0;
    step("mw_br_after");
    idle_inputs();
    step("mw_br_flush");
    step("mw_idle");

    // timeout: ready stuck low
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 9; i++) step("to_wait");
    mem_req = 0;
    step("to_after");

    // memory wait preempting LU_STALL
    rd = 5'd3; rs1 = 5'd3; mrd = 1;
    step("pre_lu");
    mem_req = 1;
    step("pre_lu_mw");
    mem_ready = 1;
    step("pre_lu_ready");
    idle_inputs();
    step("pre_lu_run");

    // async reset in the middle of LU_STALL
    rd = 5'd9; rs2 = 5'd9; mrd = 1;
    step("rst_lu_enter");
    rst_n = 0;
    #1;
    chk("rst_mid_state", 32'(hz_state), 32'd0);
    chk("rst_mid_pcw", 32'(pc_write), 32'd1);
    step("rst_mid_hold");
    rst_n = 1;
    idle_inputs();
    step("rst_mid_run");

    // random traffic
    stuck = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 70 == 35) stuck = 10;
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      mrd = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 7) == 0);
      if (stuck > 0) begin
        mem_req = 1; mem_ready = 0; stuck--;
      end else begin
        mem_req   = ($urandom_range(0, 3) == 0);
        mem_ready = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) rst_n = 0;
      step("rand");
      rst_n = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage core. It drives the write-enable, flush and hold controls of PC, IF/ID, ID/EX and EX/MEM. It detects load-use hazards from the IF/ID and ID/EX fields, handles taken-branch flushes resolved in EX, and freezes the pipe while data memory has not acknowledged. A small state machine with a cycle counter sequences multi-cycle stalls, flushes and the memory-wait timeout.

Parameters:
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 1, cycles IF/ID and ID/EX flush stay asserted after a taken branch (1..7)
MEM_TIMEOUT, 255, max cycles in MEM_WAIT before abort (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_IF_ID  in  5  source reg 1 of instruction in ID
rs2_IF_ID  in  5  source reg 2 of instruction in ID
rd_ID_EX  in  5  destination reg of instruction in EX
Mem_Read_ID_EX  in  1  instruction in EX is a load
branch_taken_EX  in  1  branch/jump resolved taken in EX
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory acknowledge
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_flush  out  1  ID/EX control fields cleared (bubble)
id_ex_hold  out  1  ID/EX keeps contents
ex_mem_hold  out  1  EX/MEM keeps contents
mem_err  out  1  one-cycle pulse on memory timeout
hz_state  out  2  current state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 FLUSH

Behaviour:
- Registered state and a 16-bit cnt. Outputs are a combinational decode of state and current inputs, giving zero-latency stalls.
- While rst_n=0: state=RUN, cnt=0. Outputs: pc_write=1, if_id_write=1, all flush/hold=0, mem_err=0, hz_state=0.
- RUN outputs: pc_write=1, if_id_write=1, all others 0, unless a hazard is detected.
- Hazard priority in any cycle: memory wait > branch flush > load-use.
- Memory wait:
  - Condition: mem_req=1 and mem_ready=0.
  - Outputs: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1.
  - Next state MEM_WAIT, cnt=1.
  - In MEM_WAIT, the same outputs hold. cnt increments each cycle.
  - mem_ready=1 returns to RUN next cycle, with outputs at RUN values in the ready cycle.
  - cnt==MEM_TIMEOUT with no ready: mem_err=1 for that cycle, then RUN.
  - branch_taken_EX is held by the frozen EX stage and re-evaluated after exit.
- Branch flush:
  - Condition: branch_taken_EX=1 in RUN or LU_STALL.
  - Outputs: if_id_flush=1, id_ex_flush=1, pc_write=1.
  - If FLUSH_CYCLES>1, enter FLUSH with cnt=1 and keep the flushes until cnt==FLUSH_CYCLES-1, then RUN.
  - A branch aborts an in-progress LU_STALL.
- Load-use:
  - Condition: Mem_Read_ID_EX=1, rd_ID_EX!=0, and (rd_ID_EX==rs1_IF_ID or rd_ID_EX==rs2_IF_ID).
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
  - If LU_STALL_CYCLES>1, enter LU_STALL with cnt=1 and repeat the outputs until cnt==LU_STALL_CYCLES-1, then RUN.
  - In LU_STALL the hazard is not re-detected; the bubble has advanced.
- Memory wait arising in FLUSH or LU_STALL preempts it. The interrupted sequence is dropped, and RUN resumes after memory is ready.
- rst_n asserted mid-sequence: immediate RUN, cnt cleared, no mem_err.
- cnt never wraps; the state exits before any limit is exceeded.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds outputs lu_stall_count[31:0], flush_count[31:0] and mem_wait_count[31:0].
- Each counter increments once per cycle in which its output pattern is asserted, saturates at 32'hFFFFFFFF, and resets to 0.
- Not defined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load-use detect: rd_ID_EX=5, Mem_Read_ID_EX=1, rs1_IF_ID=5 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, then RUN.
- Register 0 is never a hazard: rd_ID_EX=0, rs2_IF_ID=0, Mem_Read_ID_EX=1 → no stall.
- Branch beats load-use: branch_taken_EX=1 with a load-use match, FLUSH_CYCLES=2 → if_id_flush=id_ex_flush=1 for 2 cycles, pc_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → holds asserted 4 cycles, hz_state=2, RUN on the ready cycle.
- Timeout: MEM_TIMEOUT=8, mem_ready stuck 0 → mem_err pulses at the 8th MEM_WAIT cycle, then hz_state=0.
- Reset mid-sequence: rst_n=0 during LU_STALL (LU_STALL_CYCLES=3) → hz_state=0 and pc_write=1 immediately. With HAZ_PERF_CNT_EN defined, counters read 0.
